// File: rtl/mdu_iter_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned DATA_W = 32
);
  logic [2:0]        MDUOpE;
  logic [DATA_W-1:0] SrcAE;
  logic [DATA_W-1:0] SrcBE;
  logic              ExceptDealM;
  logic              MDUReadyE;
  logic [DATA_W-1:0] HiE;
  logic [DATA_W-1:0] LoE;
  logic              MDUBusyE;

  modport master (
    output MDUOpE, SrcAE, SrcBE, ExceptDealM,
    input  MDUReadyE, HiE, LoE, MDUBusyE
  );

  modport slave (
    input  MDUOpE, SrcAE, SrcBE, ExceptDealM,
    output MDUReadyE, HiE, LoE, MDUBusyE
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning HI/LO for the EX stage.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU in a single cycle with a native multiplier.
module mdu_iter #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          EARLY_ZERO = 1'b1
) (
  input logic       clk,
  input logic       resetn,
  mdu_iter_if.slave mdu
);
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                is_mul_op, is_div_op, signed_op, a_neg, b_neg, early;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum, div_shift;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next, step, res_mul;
`ifdef MDU_FAST_MUL_EN
  logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
`endif

  always_comb begin
    is_mul_op = (mdu.MDUOpE == OpMult) || (mdu.MDUOpE == OpMultu);
    is_div_op = (mdu.MDUOpE == OpDiv) || (mdu.MDUOpE == OpDivu);
    signed_op = (mdu.MDUOpE == OpMult) || (mdu.MDUOpE == OpDiv);
    a_neg     = signed_op & mdu.SrcAE[DATA_W-1];
    b_neg     = signed_op & mdu.SrcBE[DATA_W-1];
    a_mag     = a_neg ? -mdu.SrcAE : mdu.SrcAE;
    b_mag     = b_neg ? -mdu.SrcBE : mdu.SrcBE;
    early     = EARLY_ZERO &&
                ((is_mul_op && (mdu.SrcAE == '0 || mdu.SrcBE == '0)) ||
                 (is_div_op && mdu.SrcAE == '0 && mdu.SrcBE != '0));
`ifdef MDU_FAST_MUL_EN
    ext_a     = {{DATA_W{a_neg}}, mdu.SrcAE};
    ext_b     = {{DATA_W{b_neg}}, mdu.SrcBE};
    fast_prod = ext_a * ext_b;
`endif

    // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, work_q[DATA_W-1:1]};
    div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b0, opnd_q};
    div_next  = div_diff[DATA_W+1] ? {div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
                                   : {div_diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
    step      = is_div_q ? div_next : mul_next;
    res_mul   = neg_q ? -step : step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (mdu.ExceptDealM) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_mul_op || is_div_op) begin
            is_div_d  = is_div_op;
            cnt_d     = '0;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            work_d    = {{DATA_W{1'b0}}, is_div_op ? a_mag : b_mag};
            opnd_d    = is_div_op ? b_mag : a_mag;
            // Divide by zero: raw dividend with no fix-up yields LO=all ones, HI=dividend.
            if (is_div_op && mdu.SrcBE == '0) begin
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              work_d    = {{DATA_W{1'b0}}, mdu.SrcAE};
            end
            if (early) begin
              hi_d    = '0;
              lo_d    = '0;
              state_d = StDone;
`ifdef MDU_FAST_MUL_EN
            end else if (is_mul_op) begin
              {hi_d, lo_d} = fast_prod;
              state_d      = StDone;
`endif
            end else begin
              state_d = StBusy;
            end
          end else if (mdu.MDUOpE == OpMthi) begin
            hi_d = mdu.SrcAE;
          end else if (mdu.MDUOpE == OpMtlo) begin
            lo_d = mdu.SrcAE;
          end
        end
        StBusy: begin
          work_d = step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
            cnt_d   = '0;
            if (is_div_q) begin
              lo_d = neg_q ? -step[DATA_W-1:0] : step[DATA_W-1:0];
              hi_d = neg_rem_q ? -step[2*DATA_W-1:DATA_W] : step[2*DATA_W-1:DATA_W];
            end else begin
              {hi_d, lo_d} = res_mul;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      work_q    <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mdu.MDUReadyE = !(((state_q == StIdle) && (is_mul_op || is_div_op)) ||
                           (state_q == StBusy));
  assign mdu.HiE       = hi_q;
  assign mdu.LoE       = lo_q;
  assign mdu.MDUBusyE  = (state_q != StIdle);
endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected {HI,LO} queued at issue, compared when the op leaves EX.
module tb_mdu_iter;
`ifdef MDU_FAST_MUL_EN
  localparam int MulStalls = 1;
`else
  localparam int MulStalls = 33;
`endif
  localparam int DivStalls = 33;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_W(32)) bus ();

  mdu_iter #(.DATA_W(32), .EARLY_ZERO(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mdu    (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd1: return sa * sb;
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int stalls_for(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op == 3'd1 || op == 3'd2) return (a == 0 || b == 0) ? 1 : MulStalls;
    return (a == 0 && b != 0) ? 1 : DivStalls;
  endfunction

  task automatic idle();
    @(negedge clk);
    bus.MDUOpE      = 3'd0;
    bus.ExceptDealM = 1'b0;
  endtask

  // Issue an arithmetic op and hold it in EX until MDUReadyE rises.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_stalls, input string name);
    int stalls;
    logic [63:0] want;
    @(negedge clk);
    bus.MDUOpE      = op;
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    bus.ExceptDealM = 1'b0;
    sb_q.push_back(exp);
    stalls = 0;
    #1;
    while (bus.MDUReadyE !== 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      bus.SrcAE = $urandom;
      bus.SrcBE = $urandom;
      #1;
    end
    want = sb_q.pop_front();
    checks++;
    if (stalls !== exp_stalls) begin
      errors++;
      $display("FAIL %s stalls: got %0d want %0d", name, stalls, exp_stalls);
    end
    checks++;
    if ({bus.HiE, bus.LoE} !== want) begin
      errors++;
      $display("FAIL %s result: got %h_%h want %h", name, bus.HiE, bus.LoE, want);
    end
    checks++;
    if (bus.MDUBusyE !== 1'b1) begin
      errors++;
      $display("FAIL %s done busy: got %b want 1", name, bus.MDUBusyE);
    end
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    bus.MDUOpE      = 3'd0;
    bus.SrcAE       = '0;
    bus.SrcBE       = '0;
    bus.ExceptDealM = 1'b0;
    #1;
    checks++;
    if ({bus.HiE, bus.LoE, bus.MDUReadyE, bus.MDUBusyE} !== {64'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got hi=%h lo=%h rdy=%b busy=%b want 0 0 1 0",
               bus.HiE, bus.LoE, bus.MDUReadyE, bus.MDUBusyE);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MulStalls, "mult_neg");
    idle();
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MulStalls, "multu_max");
    idle();
  endtask

  task automatic test_div();
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DivStalls, "div_neg");
    idle();
    run_op(3'd4, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, DivStalls, "divu_zero");
    idle();
    run_op(3'd3, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, DivStalls, "div_zero_neg");
    idle();
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DivStalls, "div_wrap");
    idle();
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DivStalls, "div_negb");
    idle();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      run_op(op, a, b, model(op, a, b), stalls_for(op, a, b), "random");
      idle();
    end
  endtask

  task automatic test_abort();
    logic [31:0] hi0, lo0;
    hi0 = bus.HiE;
    lo0 = bus.LoE;
    @(negedge clk);
    bus.MDUOpE = 3'd4;
    bus.SrcAE  = 32'd100;
    bus.SrcBE  = 32'd7;
    for (int c = 1; c < 10; c++) @(negedge clk);
    bus.MDUOpE      = 3'd0;
    bus.ExceptDealM = 1'b1;
    #1;
    checks++;
    if ({bus.MDUBusyE, bus.MDUReadyE} !== 2'b10) begin
      errors++;
      $display("FAIL abort busy/rdy in cycle 10: got %b%b want 10", bus.MDUBusyE, bus.MDUReadyE);
    end
    @(negedge clk);
    bus.ExceptDealM = 1'b0;
    #1;
    checks++;
    if ({bus.MDUBusyE, bus.MDUReadyE} !== 2'b01) begin
      errors++;
      $display("FAIL abort idle: got busy/rdy %b%b want 01", bus.MDUBusyE, bus.MDUReadyE);
    end
    checks++;
    if ({bus.HiE, bus.LoE} !== {hi0, lo0}) begin
      errors++;
      $display("FAIL abort hilo: got %h_%h want %h_%h", bus.HiE, bus.LoE, hi0, lo0);
    end
    // Let the would-be completion time pass; nothing may be written.
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if ({bus.HiE, bus.LoE, bus.MDUBusyE} !== {hi0, lo0, 1'b0}) begin
      errors++;
      $display("FAIL abort late: got %h_%h busy=%b want %h_%h 0",
               bus.HiE, bus.LoE, bus.MDUBusyE, hi0, lo0);
    end
  endtask

  task automatic test_except_idle();
    logic [31:0] hi0;
    hi0 = bus.HiE;
    @(negedge clk);
    bus.MDUOpE      = 3'd5;
    bus.SrcAE       = ~hi0;
    bus.ExceptDealM = 1'b1;
    @(negedge clk);
    bus.MDUOpE = 3'd3;
    bus.SrcBE  = 32'd3;
    @(negedge clk);
    bus.MDUOpE      = 3'd0;
    bus.ExceptDealM = 1'b0;
    #1;
    checks++;
    if ({bus.HiE, bus.MDUBusyE} !== {hi0, 1'b0}) begin
      errors++;
      $display("FAIL except_idle: got hi=%h busy=%b want %h 0", bus.HiE, bus.MDUBusyE, hi0);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] want;
    sb_q.push_back({32'h12345678, 32'h9ABCDEF0});
    @(negedge clk);
    bus.MDUOpE = 3'd5;
    bus.SrcAE  = 32'h12345678;
    #1;
    checks++;
    if (bus.MDUReadyE !== 1'b1) begin
      errors++;
      $display("FAIL mthi ready: got %b want 1", bus.MDUReadyE);
    end
    @(negedge clk);
    bus.MDUOpE = 3'd6;
    bus.SrcAE  = 32'h9ABCDEF0;
    #1;
    checks++;
    if ({bus.MDUReadyE, bus.HiE} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL mtlo ready/hi: got %b %h want 1 12345678", bus.MDUReadyE, bus.HiE);
    end
    idle();
    #1;
    want = sb_q.pop_front();
    checks++;
    if ({bus.HiE, bus.LoE, bus.MDUBusyE} !== {want, 1'b0}) begin
      errors++;
      $display("FAIL mthi_mtlo: got %h_%h busy=%b want %h 0",
               bus.HiE, bus.LoE, bus.MDUBusyE, want);
    end
  endtask

  task automatic test_early_zero();
    run_op(3'd2, 32'd0, 32'hDEADBEEF, 64'd0, 1, "multu_zero");
    run_op(3'd1, 32'd5, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFF1, MulStalls, "back_to_back");
    run_op(3'd4, 32'd0, 32'd9, 64'd0, 1, "divu_zero_dividend");
    idle();
    #1;
    checks++;
    if ({bus.MDUBusyE, bus.MDUReadyE} !== 2'b01) begin
      errors++;
      $display("FAIL back_to_back idle: got busy/rdy %b%b want 01", bus.MDUBusyE, bus.MDUReadyE);
    end
  endtask

  task automatic test_reset_mid();
    run_op(3'd4, 32'd100, 32'd7, 64'h00000002_0000000E, DivStalls, "divu_pre_reset");
    @(negedge clk);
    bus.MDUOpE = 3'd3;
    bus.SrcAE  = 32'd1000;
    bus.SrcBE  = 32'd3;
    repeat (5) @(negedge clk);
    bus.MDUOpE = 3'd0;
    resetn     = 1'b0;
    #1;
    checks++;
    if ({bus.HiE, bus.LoE, bus.MDUBusyE, bus.MDUReadyE} !== {64'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got %h_%h busy=%b rdy=%b want 0_0 0 1",
               bus.HiE, bus.LoE, bus.MDUBusyE, bus.MDUReadyE);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_random();
    test_abort();
    test_except_idle();
    test_mthi_mtlo();
    test_early_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
